pause_ctrl: RTL and testbench
=============================

# pause_ctrl

Sequencer for the pause overlay and game freeze. Debounces the raw pause button, toggles the game between running and paused on frame boundaries, and blinks the PAUSE text enable while paused. A short solid-text countdown runs before resuming. Sits between the board button / VGA timing and the overlay renderer plus game-logic update enables.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable clocks required to accept a button level change (≥2).
- BLINK_FRAMES, 30: frames per overlay blink half-period (1..255).
- RESUME_FRAMES, 60: frames of solid overlay before the game resumes (1..255).
- clk  in  1  system/pixel clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- btn_pause  in  1  raw pause button, asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame, at the start of vertical blank.
- game_over  in  1  level; while high, pausing is disabled.
- game_run  out  1  registered; enables game-logic updates (physics, spawning, scoring).
- pause_en  out  1  registered; enable for the PAUSE text overlay.
- paused  out  1  registered; high in every state except RUN.

## Operation
- Button path:
  - 2-FF synchronizer gives btn_s.
  - Debounced level btn_db has counter cnt.
  - If btn_s == btn_db, cnt clears.
  - Otherwise cnt increments. When cnt == DEBOUNCE_CYCLES-1, btn_db <= btn_s and cnt clears.
  - press = btn_db & ~btn_db_d: one cycle per accepted rising edge. A release generates no press.
- FSM states: RUN, PAUSE_REQ, PAUSED, RESUME.
  - RUN: press & !game_over -> PAUSE_REQ.
  - PAUSE_REQ: frame_tick -> PAUSED. Clear the blink counter and set blink_ph=1.
  - PAUSED:
    - On frame_tick, the blink counter increments. At BLINK_FRAMES-1 it clears and blink_ph toggles.
    - press -> RESUME, with the resume counter cleared.
  - RESUME:
    - On frame_tick, the resume counter increments. On the tick where it equals RESUME_FRAMES-1 -> RUN.
    - press in the same or any earlier RESUME cycle -> PAUSED (cancel). Blink restarts with blink_ph=1.
    - press has priority over the final tick.
- game_over high, any state: next state RUN and all counters cleared. It overrides press and frame_tick.
- Output decode, registered from next state:
  - RUN: run=1, en=0.
  - PAUSE_REQ: run=1, en=0.
  - PAUSED: run=0, en=blink_ph.
  - RESUME: run=0, en=1.
  - paused = (next state != RUN).
- Presses arriving in PAUSE_REQ are ignored; a pause request cannot be cancelled.

## Timing
- Reset values: state RUN, game_run=1, pause_en=0, paused=0, btn_db=0, all counters 0, synchronizer 0.
- btn_pause rise to press: 2 sync cycles plus DEBOUNCE_CYCLES cycles. press is combinational in the cycle btn_db rises.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no press.
- Outputs change one clk after the triggering press or frame_tick edge is sampled.
- Freeze and resume always occur on the clock after a frame_tick, never mid-frame.
- Overlay blink period is 2*BLINK_FRAMES frames. The first half-period is on.
- press and frame_tick in the same RUN cycle: go to PAUSE_REQ and wait for the next frame_tick.
- Asynchronous reset mid-operation returns immediately to the reset values. The button must be re-qualified after reset.

## Structure
- Package pause_pkg holds:
  - The state enum (RUN, PAUSE_REQ, PAUSED, RESUME), 2 bits.
  - Frame counter width constant FCNT_W=8.
- Sub-module btn_debounce (synchronizer, debounce counter, press edge) with parameter DEBOUNCE_CYCLES. The counter width is $clog2(DEBOUNCE_CYCLES).
- pause_ctrl holds the FSM, the blink and resume counters, and the output registers.
- pause_en drives the overlay enable input directly.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, BLINK_FRAMES=2, RESUME_FRAMES=3, frame_tick every 20 clks.
- Reset asserted mid-PAUSED -> outputs 1/0/0 during reset. After release, no press until btn is held ≥6 clks.
- btn pulses of 3 clks, then a 6-clk hold -> exactly one press, after the hold only. FSM reaches PAUSE_REQ; game_run stays 1 until the next frame_tick, then drops to 0.
- Paused for 8 ticks -> pause_en pattern per frame is 1,1,0,0,1,1,0,0. game_run=0 and paused=1 throughout.
- press in PAUSED -> pause_en solid 1. After 3 frame_ticks, game_run=1, pause_en=0, paused=0 one clk after the third tick.
- press during RESUME after 2 ticks -> back to PAUSED with blink restarting on. A later full resume still needs 3 new ticks.
- game_over=1 in PAUSED -> next clk game_run=1, pause_en=0, paused=0. Presses while game_over=1 leave the FSM in RUN.

Source files
------------

// File: rtl/pause_pkg.sv
// Shared types and constants for the pause overlay sequencer.
package pause_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    PAUSE_REQ = 2'd1,
    PAUSED    = 2'd2,
    RESUME    = 2'd3
  } state_e;

  localparam int FCNT_W = 8;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces the raw pause button.
// Emits a one-cycle press on each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          db_dly_q, db_dly_d;
  logic          btn_s;

  assign btn_s = sync_q[1];

  always_comb begin
    sync_d   = {sync_q[0], btn_raw};
    cnt_d    = cnt_q;
    db_d     = db_q;
    db_dly_d = db_q;
    // Any return to the accepted level restarts qualification.
    if (btn_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = btn_s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
    end
  end

  assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/pause_ctrl.sv
// Pause sequencer: frame-aligned freeze/resume, blinking PAUSE overlay
// while paused and a solid-overlay countdown before resuming.
module pause_ctrl
  import pause_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_FRAMES    = 30,
  parameter int RESUME_FRAMES   = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_pause,
  input  logic frame_tick,
  input  logic game_over,
  output logic game_run,
  output logic pause_en,
  output logic paused
);

  localparam logic [FCNT_W-1:0] BLINK_LAST  = FCNT_W'(BLINK_FRAMES - 1);
  localparam logic [FCNT_W-1:0] RESUME_LAST = FCNT_W'(RESUME_FRAMES - 1);

  logic              press;
  state_e            state_q, state_d;
  logic [FCNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [FCNT_W-1:0] res_cnt_q, res_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic              game_run_q, game_run_d;
  logic              pause_en_q, pause_en_d;
  logic              paused_q, paused_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_pause),
    .press   (press)
  );

  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    res_cnt_d   = res_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (game_over) begin
      state_d     = RUN;
      blink_cnt_d = '0;
      res_cnt_d   = '0;
      blink_ph_d  = 1'b0;
    end else begin
      unique case (state_q)
        RUN: if (press) state_d = PAUSE_REQ;
        PAUSE_REQ: begin
          if (frame_tick) begin
            state_d     = PAUSED;
            blink_cnt_d = '0;
            blink_ph_d  = 1'b1;
          end
        end
        PAUSED: begin
          if (press) begin
            state_d   = RESUME;
            res_cnt_d = '0;
          end else if (frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              blink_ph_d  = ~blink_ph_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 1'b1;
            end
          end
        end
        RESUME: begin
          // A press cancels even when it coincides with the final tick.
          if (press) begin
            state_d     = PAUSED;
            blink_cnt_d = '0;
            blink_ph_d  = 1'b1;
          end else if (frame_tick) begin
            if (res_cnt_q == RESUME_LAST) begin
              state_d   = RUN;
              res_cnt_d = '0;
            end else begin
              res_cnt_d = res_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    game_run_d = (state_d == RUN) || (state_d == PAUSE_REQ);
    pause_en_d = (state_d == RESUME) || ((state_d == PAUSED) && blink_ph_d);
    paused_d   = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      blink_cnt_q <= '0;
      res_cnt_q   <= '0;
      blink_ph_q  <= 1'b0;
      game_run_q  <= 1'b1;
      pause_en_q  <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      blink_cnt_q <= blink_cnt_d;
      res_cnt_q   <= res_cnt_d;
      blink_ph_q  <= blink_ph_d;
      game_run_q  <= game_run_d;
      pause_en_q  <= pause_en_d;
      paused_q    <= paused_d;
    end
  end

  assign game_run = game_run_q;
  assign pause_en = pause_en_q;
  assign paused   = paused_q;

endmodule

// File: tb/tb_pause_ctrl.sv
// Directed bench for pause_ctrl; checks {game_run,pause_en,paused}.
module tb_pause_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic ft = 1'b0;
  logic go = 1'b0;
  logic game_run, pause_en, paused;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] pat;

  pause_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .BLINK_FRAMES    (2),
    .RESUME_FRAMES   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_pause  (btn),
    .frame_tick (ft),
    .game_over  (go),
    .game_run   (game_run),
    .pause_en   (pause_en),
    .paused     (paused)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [2:0] exp);
    tests++;
    assert ({game_run, pause_en, paused} === exp)
    else begin
      fails++;
      $error("FAIL %s: run/en/paused got %b want %b", tag, {game_run, pause_en, paused}, exp);
    end
  endtask

  // One-cycle frame_tick; returns at the negedge after it was sampled.
  task automatic tick();
    ft = 1'b1;
    cyc(1);
    ft = 1'b0;
  endtask

  task automatic frame();
    cyc(19);
    tick();
  endtask

  // Hold the button n clocks; optionally land a frame_tick on the press cycle.
  task automatic hold_btn(input int n, input bit tick_on_press);
    btn = 1'b1;
    cyc(n);
    btn = 1'b0;
    ft  = tick_on_press;
    cyc(1);
    ft  = 1'b0;
    cyc(9);
  endtask

  initial begin
    cyc(2);
    chk("reset", 3'b100);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_run", 3'b100);

    hold_btn(3, 1'b0);
    chk("glitch1", 3'b100);
    hold_btn(3, 1'b0);
    chk("glitch2", 3'b100);
    hold_btn(6, 1'b0);
    chk("pause_req", 3'b101);
    hold_btn(6, 1'b0);
    chk("req_ignores_press", 3'b101);

    frame();
    chk("frozen", 3'b011);
    pat = 8'b0011_0011;
    for (int i = 1; i < 8; i++) begin
      frame();
      chk($sformatf("blink%0d", i), {1'b0, pat[i], 1'b1});
    end

    hold_btn(6, 1'b0);
    chk("resume_enter", 3'b011);
    frame();
    chk("res_t1", 3'b011);
    frame();
    chk("res_t2", 3'b011);
    hold_btn(6, 1'b0);
    chk("cancel", 3'b011);
    frame();
    chk("reblink1", 3'b011);
    frame();
    chk("reblink2", 3'b001);

    hold_btn(6, 1'b0);
    chk("resume2_enter", 3'b011);
    frame();
    frame();
    chk("resume2_t2", 3'b011);
    frame();
    chk("resumed", 3'b100);

    hold_btn(6, 1'b1);
    chk("press_and_tick", 3'b101);
    frame();
    chk("frozen2", 3'b011);

    go = 1'b1;
    cyc(1);
    chk("game_over", 3'b100);
    hold_btn(6, 1'b0);
    chk("go_press", 3'b100);
    frame();
    chk("go_tick", 3'b100);
    go = 1'b0;
    cyc(2);
    chk("go_clear", 3'b100);

    hold_btn(6, 1'b0);
    frame();
    chk("frozen3", 3'b011);
    cyc(3);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 3'b100);
    cyc(2);
    chk("in_rst", 3'b100);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst", 3'b100);
    hold_btn(3, 1'b0);
    chk("post_rst_glitch", 3'b100);
    hold_btn(6, 1'b0);
    chk("post_rst_press", 3'b101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
